// File: rtl/normalization_controller.sv
// normalization_controller: sequences one requantization job (read rows, normalize, buffer, write back).
// Optional feature macro NORM_CTRL_PERF_EN adds the saturating StallCycles output.
module normalization_controller #(
    parameter int OUT_WIDTH  = 8,
    parameter int SA_LENGTH  = 256,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                                  Clk,
    input  logic                                  Rst_n,
    input  logic                                  CmdValid,
    output logic                                  CmdReady,
    input  logic [ADDR_WIDTH-1:0]                 CmdSrcBase,
    input  logic [ADDR_WIDTH-1:0]                 CmdDstBase,
    input  logic [ADDR_WIDTH:0]                   CmdRows,
    input  logic signed [7:0]                     CmdShift,
    input  logic signed [OUT_WIDTH-1:0]           CmdZ,
    output logic signed [7:0]                     ShiftAmmount,
    output logic signed [OUT_WIDTH-1:0]           Z,
    output logic                                  RdEn,
    output logic [ADDR_WIDTH-1:0]                 RdAddr,
    input  logic signed [OUT_WIDTH*SA_LENGTH-1:0] NormOut,
    output logic                                  WrValid,
    input  logic                                  WrReady,
    output logic [ADDR_WIDTH-1:0]                 WrAddr,
    output logic [OUT_WIDTH*SA_LENGTH-1:0]        WrData,
    output logic                                  Busy,
    output logic                                  Done,
`ifdef NORM_CTRL_PERF_EN
    output logic [31:0]                           StallCycles,
`endif
    output logic [1:0]                            DbgState
);
    localparam int DW = OUT_WIDTH * SA_LENGTH;
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_src_base;
    logic [ADDR_WIDTH-1:0] r_dst_base;
    logic [CW-1:0]         r_rows;
    logic [CW-1:0]         r_issued;
    logic [CW-1:0]         r_captured;
    logic [CW-1:0]         r_written;
    logic                  r_inflight;
    logic [DW-1:0]         r_fifo_data [2];
    logic [ADDR_WIDTH-1:0] r_fifo_addr [2];
    logic                  r_fifo_rd_ptr;
    logic                  r_fifo_wr_ptr;
    logic [1:0]            r_fifo_count;

    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_credit_ok;
    logic w_rd_en;
    logic w_last_issue;

    // Handshakes: a command transfers on CmdValid && CmdReady, a row transfers on WrValid && WrReady;
    // the head (WrValid/WrAddr/WrData) never changes while WrValid && !WrReady.
    always_comb begin
        w_accept     = (r_state == S_IDLE) && CmdValid;
        w_push       = r_inflight;
        w_pop        = (r_fifo_count != 2'd0) && WrReady;
        // count + in-flight - pop < 2, rearranged so nothing underflows
        w_credit_ok  = ({1'b0, r_fifo_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
        w_rd_en      = (r_state == S_RUN) && (r_issued < r_rows) && w_credit_ok;
        w_last_issue = w_rd_en && ((r_issued + CNT_ONE) == r_rows);
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (CmdValid) w_next_state = (CmdRows == '0) ? S_DONE : S_RUN;
            S_RUN:   if (w_last_issue) w_next_state = S_DRAIN;
            S_DRAIN: if (!r_inflight && (r_fifo_count == 2'd0) && (r_written == r_rows))
                         w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_src_base   <= '0;
            r_dst_base   <= '0;
            r_rows       <= '0;
            r_issued     <= '0;
            r_captured   <= '0;
            r_written    <= '0;
            r_inflight   <= 1'b0;
            ShiftAmmount <= '0;
            Z            <= '0;
        end else begin
            if (w_accept) begin
                r_src_base   <= CmdSrcBase;
                r_dst_base   <= CmdDstBase;
                r_rows       <= CmdRows;
                ShiftAmmount <= CmdShift;
                Z            <= CmdZ;
                r_issued     <= '0;
                r_captured   <= '0;
                r_written    <= '0;
            end else begin
                if (w_rd_en) r_issued   <= r_issued + CNT_ONE;
                if (w_push)  r_captured <= r_captured + CNT_ONE;
                if (w_pop)   r_written  <= r_written + CNT_ONE;
            end
            r_inflight <= w_rd_en;
        end
    end

    // Two-entry FIFO; push into the slot being popped is safe because the head is read combinationally.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_addr[i] <= '0;
            end
            r_fifo_rd_ptr <= 1'b0;
            r_fifo_wr_ptr <= 1'b0;
            r_fifo_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_fifo_wr_ptr] <= NormOut;
                r_fifo_addr[r_fifo_wr_ptr] <= r_dst_base + r_captured[ADDR_WIDTH-1:0];
                r_fifo_wr_ptr              <= ~r_fifo_wr_ptr;
            end
            if (w_pop) r_fifo_rd_ptr <= ~r_fifo_rd_ptr;
            r_fifo_count <= r_fifo_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign CmdReady = (r_state == S_IDLE);
    assign Busy     = (r_state != S_IDLE);
    assign Done     = (r_state == S_DONE);
    assign RdEn     = w_rd_en;
    assign RdAddr   = r_src_base + r_issued[ADDR_WIDTH-1:0];
    assign WrValid  = (r_fifo_count != 2'd0);
    assign WrAddr   = r_fifo_addr[r_fifo_rd_ptr];
    assign WrData   = r_fifo_data[r_fifo_rd_ptr];
    assign DbgState = r_state;

`ifdef NORM_CTRL_PERF_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            r_stall_cycles <= '0;
        else if (w_accept)
            r_stall_cycles <= '0;
        else if (WrValid && !WrReady && (r_stall_cycles != 32'hFFFF_FFFF))
            r_stall_cycles <= r_stall_cycles + 32'd1;
    end

    assign StallCycles = r_stall_cycles;
`endif
endmodule
